// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e     : sequencing FSM encodings (RUN/STALL/FLUSH/HALT)
//   FWD_*       : Execute operand forwarding select codes
//   NOP_INSTR   : instruction word loaded into F/D when it is flushed
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'b00,
    StStall = 2'b01,
    StFlush = 2'b10,
    StHalt  = 2'b11
  } state_e;

  localparam logic [1:0] FWD_REG = 2'b00;  // register file value
  localparam logic [1:0] FWD_MEM = 2'b01;  // E/M stage result
  localparam logic [1:0] FWD_WB  = 2'b10;  // M/W stage result

  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding compare for a single Execute operand.
// Ports:
//   src              operand register address
//   m_dst/m_regwrite E/M stage destination and write flag
//   w_dst/w_regwrite M/W stage destination and write flag
//   sel              operand select (FWD_MEM over FWD_WB over FWD_REG)
module hazard_ctrl_fwd_unit
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0] src,
  input  logic [N-1:0] m_dst,
  input  logic         m_regwrite,
  input  logic [N-1:0] w_dst,
  input  logic         w_regwrite,
  output logic [1:0]   sel
);

  // The younger E/M result wins over M/W; register 0 is an ordinary register.
  always_comb begin
    sel = FWD_REG;
    if (m_regwrite && (m_dst == src)) begin
      sel = FWD_MEM;
    end else if (w_regwrite && (w_dst == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage processor.
// Watches Decode and the D/E, E/M, M/W control fields; drives PC/F-D/D-E
// enables, F/D flush, D/E bubble, operand forwarding selects and the
// RUN/STALL/FLUSH/HALT sequencing FSM.
// Ports:
//   clk, rst              clock; synchronous active-low reset
//   d_*                   Decode operands, use flags and HLT flag
//   resume                restart from HALT
//   e_*, m_*, w_*         downstream stage destination/control fields
//   mem_busy              freeze the whole pipe
//   pc_en, fd_en, de_en   buffer load enables
//   fd_flush, de_bubble   squash controls
//   fwd_a, fwd_b          Execute operand selects
//   state                 FSM state (debug)
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned N            = 3,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d_src,
  input  logic [N-1:0] d_dst,
  input  logic         d_use_src,
  input  logic         d_use_dst,
  input  logic         d_halt,
  input  logic         resume,
  input  logic [N-1:0] e_dst,
  input  logic         e_regwrite,
  input  logic         e_memread,
  input  logic         e_branch_taken,
  input  logic [N-1:0] m_dst,
  input  logic         m_regwrite,
  input  logic [N-1:0] w_dst,
  input  logic         w_regwrite,
  input  logic         mem_busy,
  output logic         pc_en,
  output logic         fd_en,
  output logic         fd_flush,
  output logic         de_en,
  output logic         de_bubble,
  output logic [1:0]   fwd_a,
  output logic [1:0]   fwd_b,
  output logic [1:0]   state
);

  // Counter holds the flush cycles still owed after the branch cycle itself.
  localparam logic [1:0] FlushInit = 2'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       luh;
  logic [1:0] sel_a, sel_b;

  assign luh = e_memread && e_regwrite &&
               ((d_use_src && (d_src == e_dst)) || (d_use_dst && (d_dst == e_dst)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StRun;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    de_en     = 1'b1;
    fd_flush  = 1'b0;
    de_bubble = 1'b0;
    if (!rst) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      de_en     = 1'b0;
      fd_flush  = 1'b1;
      de_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_en = 1'b0;
      fd_en = 1'b0;
      de_en = 1'b0;
    end else if (e_branch_taken) begin
      // Branch target loads into the PC while the wrong-path work is squashed.
      fd_flush  = 1'b1;
      de_bubble = 1'b1;
      cnt_d     = FlushInit;
      state_d   = (FLUSH_CYCLES > 1) ? StFlush : StRun;
    end else begin
      unique case (state_q)
        StFlush: begin
          fd_flush  = 1'b1;
          de_bubble = 1'b1;
          if (cnt_q <= 2'd1) begin
            cnt_d   = 2'd0;
            state_d = StRun;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        StHalt: begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          de_bubble = 1'b1;
          if (resume) state_d = StRun;
        end
        StStall: begin
          // Load is now in E/M, forwarding covers it.
          state_d = StRun;
        end
        StRun: begin
          if (d_halt) begin
            // HLT itself advances into D/E; fetch stops behind it.
            pc_en   = 1'b0;
            fd_en   = 1'b0;
            state_d = StHalt;
          end else if (luh) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_bubble = 1'b1;
            state_d   = StStall;
          end
        end
      endcase
    end
  end

  hazard_ctrl_fwd_unit #(.N(N)) u_fwd_a (
    .src        (d_src),
    .m_dst      (m_dst),
    .m_regwrite (m_regwrite),
    .w_dst      (w_dst),
    .w_regwrite (w_regwrite),
    .sel        (sel_a)
  );

  hazard_ctrl_fwd_unit #(.N(N)) u_fwd_b (
    .src        (d_dst),
    .m_dst      (m_dst),
    .m_regwrite (m_regwrite),
    .w_dst      (w_dst),
    .w_regwrite (w_regwrite),
    .sel        (sel_b)
  );

  assign fwd_a = rst ? sel_a : FWD_REG;
  assign fwd_b = rst ? sel_b : FWD_REG;
  assign state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] d_src, d_dst, e_dst, m_dst, w_dst;
  logic       d_use_src, d_use_dst, d_halt, resume;
  logic       e_regwrite, e_memread, e_branch_taken;
  logic       m_regwrite, w_regwrite, mem_busy;
  logic       pc_en, fd_en, fd_flush, de_en, de_bubble;
  logic [1:0] fwd_a, fwd_b, state;

  int checks = 0;
  int failures = 0;

  localparam logic [1:0] S_RUN = 2'b00, S_STALL = 2'b01, S_FLUSH = 2'b10, S_HALT = 2'b11;

  always #5 clk = ~clk;

  hazard_ctrl #(.N(3), .FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .d_src          (d_src),
    .d_dst          (d_dst),
    .d_use_src      (d_use_src),
    .d_use_dst      (d_use_dst),
    .d_halt         (d_halt),
    .resume         (resume),
    .e_dst          (e_dst),
    .e_regwrite     (e_regwrite),
    .e_memread      (e_memread),
    .e_branch_taken (e_branch_taken),
    .m_dst          (m_dst),
    .m_regwrite     (m_regwrite),
    .w_dst          (w_dst),
    .w_regwrite     (w_regwrite),
    .mem_busy       (mem_busy),
    .pc_en          (pc_en),
    .fd_en          (fd_en),
    .fd_flush       (fd_flush),
    .de_en          (de_en),
    .de_bubble      (de_bubble),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .state          (state)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs settle well away from it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // {pc_en, fd_en, de_en, fd_flush, de_bubble}
  function automatic logic [7:0] ctl();
    return {3'b000, pc_en, fd_en, de_en, fd_flush, de_bubble};
  endfunction

  initial begin
    rst = 1'b0;
    {d_src, d_dst, e_dst, m_dst, w_dst} = '0;
    {d_use_src, d_use_dst, d_halt, resume} = '0;
    {e_regwrite, e_memread, e_branch_taken, m_regwrite, w_regwrite, mem_busy} = '0;

    // Reset
    step();
    check_eq("rst_ctl", ctl(), 8'b00011);
    check_eq("rst_fwd", {4'b0, fwd_a, fwd_b}, 8'h00);
    step();
    rst = 1'b1;
    #1;
    check_eq("post_rst_state", 8'(state), 8'(S_RUN));
    check_eq("post_rst_ctl", ctl(), 8'b11100);
    check_eq("post_rst_fwd", {4'b0, fwd_a, fwd_b}, 8'h00);

    // Load-use on R3
    e_memread = 1; e_regwrite = 1; e_dst = 3; d_use_src = 1; d_src = 3;
    #1;
    check_eq("luh_ctl", ctl(), 8'b00101);
    check_eq("luh_state", 8'(state), 8'(S_RUN));
    step();
    e_memread = 0; e_regwrite = 0; m_dst = 3; m_regwrite = 1;
    #1;
    check_eq("stall_state", 8'(state), 8'(S_STALL));
    check_eq("stall_ctl", ctl(), 8'b11100);
    check_eq("stall_fwd_a", 8'(fwd_a), 8'h01);
    step();
    m_regwrite = 0;
    #1;
    check_eq("after_stall_state", 8'(state), 8'(S_RUN));

    // Taken branch together with a load-use: no STALL
    e_memread = 1; e_regwrite = 1; e_branch_taken = 1;
    #1;
    check_eq("br_ctl", ctl(), 8'b11111);
    step();
    e_branch_taken = 0;
    #1;
    check_eq("flush_state", 8'(state), 8'(S_FLUSH));
    check_eq("flush_ctl", ctl(), 8'b11111);
    step();
    e_memread = 0; e_regwrite = 0;
    #1;
    check_eq("flush_done_state", 8'(state), 8'(S_RUN));
    check_eq("flush_done_ctl", ctl(), 8'b11100);

    // Forwarding priority on operand B
    d_use_src = 0; d_src = 1; d_dst = 5; m_dst = 5; w_dst = 5; m_regwrite = 1; w_regwrite = 1;
    #1;
    check_eq("fwd_b_mem", 8'(fwd_b), 8'h01);
    check_eq("fwd_a_none", 8'(fwd_a), 8'h00);
    m_regwrite = 0;
    #1;
    check_eq("fwd_b_wb", 8'(fwd_b), 8'h02);
    w_regwrite = 0;
    #1;
    check_eq("fwd_b_reg", 8'(fwd_b), 8'h00);
    d_src = 0; m_dst = 0; m_regwrite = 1;
    #1;
    check_eq("fwd_a_r0", 8'(fwd_a), 8'h01);
    m_regwrite = 0;

    // resume in RUN does nothing
    resume = 1;
    step();
    resume = 0;
    #1;
    check_eq("resume_run_state", 8'(state), 8'(S_RUN));

    // HALT
    d_halt = 1;
    #1;
    check_eq("hlt_ctl", ctl(), 8'b00100);
    step();
    d_halt = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("halt_state", 8'(state), 8'(S_HALT));
      check_eq("halt_ctl", ctl(), 8'b00101);
      step();
    end
    resume = 1;
    #1;
    check_eq("resume_cycle_ctl", ctl(), 8'b00101);
    step();
    resume = 0;
    #1;
    check_eq("resumed_state", 8'(state), 8'(S_RUN));
    check_eq("resumed_ctl", ctl(), 8'b11100);

    // mem_busy freezes FLUSH with one cycle owed
    e_branch_taken = 1;
    step();
    e_branch_taken = 0;
    mem_busy = 1;
    #1;
    check_eq("busy_ctl", ctl(), 8'b00000);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("busy_state", 8'(state), 8'(S_FLUSH));
    end
    mem_busy = 0;
    #1;
    check_eq("busy_rel_ctl", ctl(), 8'b11111);
    step();
    check_eq("busy_rel_state", 8'(state), 8'(S_RUN));
    check_eq("busy_rel_run_ctl", ctl(), 8'b11100);

    // Reset in the middle of HALT
    d_halt = 1;
    step();
    d_halt = 0;
    check_eq("pre_rst_halt", 8'(state), 8'(S_HALT));
    rst = 0;
    #1;
    check_eq("mid_rst_ctl", ctl(), 8'b00011);
    step();
    rst = 1;
    #1;
    check_eq("mid_rst_state", 8'(state), 8'(S_RUN));
    check_eq("mid_rst_run_ctl", ctl(), 8'b11100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
